// File: rtl/fwd_hazard_unit_if.sv
// Handshake bundle between the ID/EX control path and the forwarding/hazard unit.
// Statistics counters exist only when HAZARD_STATS_EN is defined.
interface fwd_hazard_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic                  stall;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
`ifdef HAZARD_STATS_EN
  logic [31:0]           stat_stall_cnt;
  logic [31:0]           stat_fwd_mem_cnt;
  logic [31:0]           stat_fwd_wb_cnt;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
`ifdef HAZARD_STATS_EN
    input  stat_stall_cnt, stat_fwd_mem_cnt, stat_fwd_wb_cnt,
`endif
    input  stall, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
`ifdef HAZARD_STATS_EN
    output stat_stall_cnt, stat_fwd_mem_cnt, stat_fwd_wb_cnt,
`endif
    output stall, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generator for the 5-stage pipeline; shadows rd of EX/MEM/WB.
// Optional HAZARD_STATS_EN adds free-running stall/forward event counters.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter bit XZERO_NOFWD = 1'b1
) (
  input logic              clk,
  input logic              reset,
  fwd_hazard_unit_if.slave hz
);
  localparam int W = REG_ADDR_W;

  logic         ex_valid_q, ex_use_rs1_q, ex_use_rs2_q, ex_reg_write_q, ex_mem_read_q;
  logic [W-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic         mem_valid_q, mem_reg_write_q, mem_mem_read_q;
  logic [W-1:0] mem_rd_q;
  logic         wb_valid_q, wb_reg_write_q;
  logic [W-1:0] wb_rd_q;

  logic         load_use;
  logic [1:0]   fwd_a, fwd_b;

  function automatic logic rd_live(input logic [W-1:0] rd);
    return !(XZERO_NOFWD && (rd == '0));
  endfunction

  function automatic logic producer_hit(input logic v, input logic rw,
                                        input logic [W-1:0] rd, input logic use_src,
                                        input logic [W-1:0] src);
    return v && rw && use_src && rd_live(rd) && (rd == src);
  endfunction

  // Youngest producer (EX/MEM) wins over MEM/WB; a bubble in EX selects the register file.
  function automatic logic [1:0] pick_sel(input logic ex_v, input logic mem_hit, input logic wb_hit);
    if (!ex_v)   return 2'b00;
    if (mem_hit) return 2'b10;
    if (wb_hit)  return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    load_use = 1'b0;
    if (hz.id_valid && !hz.flush && ex_valid_q && ex_mem_read_q && ex_reg_write_q && rd_live(ex_rd_q))
      load_use = (hz.id_use_rs1 && (hz.id_rs1 == ex_rd_q)) ||
                 (hz.id_use_rs2 && (hz.id_rs2 == ex_rd_q));
  end

  always_comb begin
    fwd_a = pick_sel(ex_valid_q,
                     producer_hit(mem_valid_q, mem_reg_write_q, mem_rd_q, ex_use_rs1_q, ex_rs1_q),
                     producer_hit(wb_valid_q,  wb_reg_write_q,  wb_rd_q,  ex_use_rs1_q, ex_rs1_q));
    fwd_b = pick_sel(ex_valid_q,
                     producer_hit(mem_valid_q, mem_reg_write_q, mem_rd_q, ex_use_rs2_q, ex_rs2_q),
                     producer_hit(wb_valid_q,  wb_reg_write_q,  wb_rd_q,  ex_use_rs2_q, ex_rs2_q));
  end

  assign hz.stall     = load_use;
  assign hz.fwd_a_sel = fwd_a;
  assign hz.fwd_b_sel = fwd_b;

  // Stage valids: stall or flush turns the ID->EX issue into a bubble; MEM/WB always advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      ex_valid_q  <= hz.id_valid && !load_use && !hz.flush;
      mem_valid_q <= ex_valid_q;
      wb_valid_q  <= mem_valid_q;
    end
  end

  // Stage payloads carry no reset; every consumer qualifies them with the stage valid.
  always_ff @(posedge clk) begin
    ex_rs1_q        <= hz.id_rs1;
    ex_rs2_q        <= hz.id_rs2;
    ex_use_rs1_q    <= hz.id_use_rs1;
    ex_use_rs2_q    <= hz.id_use_rs2;
    ex_rd_q         <= hz.id_rd;
    ex_reg_write_q  <= hz.id_reg_write;
    ex_mem_read_q   <= hz.id_mem_read;
    mem_rd_q        <= ex_rd_q;
    mem_reg_write_q <= ex_reg_write_q;
    mem_mem_read_q  <= ex_mem_read_q;
    wb_rd_q         <= mem_rd_q;
    wb_reg_write_q  <= mem_reg_write_q;
  end

  // A load still in MEM can never feed EX: the stall must have separated them.
  assert property (@(posedge clk) disable iff (reset)
    !(ex_valid_q && mem_mem_read_q &&
      (producer_hit(mem_valid_q, mem_reg_write_q, mem_rd_q, ex_use_rs1_q, ex_rs1_q) ||
       producer_hit(mem_valid_q, mem_reg_write_q, mem_rd_q, ex_use_rs2_q, ex_rs2_q))));

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_mem_cnt_q, fwd_mem_cnt_d;
  logic [31:0] fwd_wb_cnt_q, fwd_wb_cnt_d;

  always_comb begin
    stall_cnt_d   = stall_cnt_q + 32'(load_use);
    fwd_mem_cnt_d = fwd_mem_cnt_q + 32'(fwd_a == 2'b10) + 32'(fwd_b == 2'b10);
    fwd_wb_cnt_d  = fwd_wb_cnt_q + 32'(fwd_a == 2'b01) + 32'(fwd_b == 2'b01);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q   <= '0;
      fwd_mem_cnt_q <= '0;
      fwd_wb_cnt_q  <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      fwd_mem_cnt_q <= fwd_mem_cnt_d;
      fwd_wb_cnt_q  <= fwd_wb_cnt_d;
    end
  end

  assign hz.stat_stall_cnt   = stall_cnt_q;
  assign hz.stat_fwd_mem_cnt = fwd_mem_cnt_q;
  assign hz.stat_fwd_wb_cnt  = fwd_wb_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: reset, ALU/ALU, distance-2, priority, load-use, x0, flush and mid-run reset.
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.REG_ADDR_W(5)) hz();
  fwd_hazard_unit #(.REG_ADDR_W(5), .XZERO_NOFWD(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr);
    hz.id_valid     = v;
    hz.id_rs1       = rs1;
    hz.id_rs2       = rs2;
    hz.id_use_rs1   = u1;
    hz.id_use_rs2   = u2;
    hz.id_rd        = rd;
    hz.id_reg_write = rw;
    hz.id_mem_read  = mr;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    hz.flush = 1'b0;
    // Reset held two cycles while ID presents a load/consumer pattern
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
    nxt(); mid();
    check_eq("rst1_stall", 32'(hz.stall), 32'd0);
    check_eq("rst1_fa", 32'(hz.fwd_a_sel), 32'd0);
    check_eq("rst1_fb", 32'(hz.fwd_b_sel), 32'd0);
    nxt(); mid();
    check_eq("rst2_stall", 32'(hz.stall), 32'd0);
    check_eq("rst2_fa", 32'(hz.fwd_a_sel), 32'd0);
    check_eq("rst2_fb", 32'(hz.fwd_b_sel), 32'd0);
    nxt();
    reset = 1'b0;
    nop();
    nxt();

    // ALU -> ALU back-to-back: add x5; sub x6, x5, x5
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    mid(); check_eq("alu_prod_stall", 32'(hz.stall), 32'd0); nxt();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    mid(); check_eq("alu_cons_stall", 32'(hz.stall), 32'd0); nxt();
    nop();
    mid();
    check_eq("alu_fa", 32'(hz.fwd_a_sel), 32'd2);
    check_eq("alu_fb", 32'(hz.fwd_b_sel), 32'd2);
    nxt();

    // Distance 2: add x7; nop; consumer rs1=x1, rs2=x7
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    mid(); check_eq("bubble_fa", 32'(hz.fwd_a_sel), 32'd0); nxt();
    nop(); nxt();
    drive(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0); nxt();
    nop();
    mid();
    check_eq("d2_fa", 32'(hz.fwd_a_sel), 32'd0);
    check_eq("d2_fb", 32'(hz.fwd_b_sel), 32'd1);
    nxt();

    // Priority: two writers of x7 back-to-back, then consumer of rs2=x7
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0); nxt();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0); nxt();
    drive(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0); nxt();
    nop();
    mid();
    check_eq("prio_fa", 32'(hz.fwd_a_sel), 32'd0);
    check_eq("prio_fb", 32'(hz.fwd_b_sel), 32'd2);
    nxt();

    // Load-use: lw x3; add rs1=x3, rs2=x9
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    mid(); check_eq("lw_issue_stall", 32'(hz.stall), 32'd0); nxt();
    drive(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    mid(); check_eq("lu_stall", 32'(hz.stall), 32'd1); nxt();
    mid();
    check_eq("lu_stall_clear", 32'(hz.stall), 32'd0);
    check_eq("lu_bubble_fa", 32'(hz.fwd_a_sel), 32'd0);
    nxt();
    nop();
    mid();
    check_eq("lu_fa", 32'(hz.fwd_a_sel), 32'd1);
    check_eq("lu_fb", 32'(hz.fwd_b_sel), 32'd0);
    nxt();

    // x0: lw x0, then reader of x0 on both operands
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1); nxt();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    mid(); check_eq("x0_stall", 32'(hz.stall), 32'd0); nxt();
    nop();
    mid();
    check_eq("x0_fa", 32'(hz.fwd_a_sel), 32'd0);
    check_eq("x0_fb", 32'(hz.fwd_b_sel), 32'd0);
    nxt();

    // Unused operand: lw x4, then reader with rs2=x4 but use_rs2=0
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1); nxt();
    drive(1'b1, 5'd0, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    mid(); check_eq("unused_stall", 32'(hz.stall), 32'd0); nxt();
    nop();
    mid(); check_eq("unused_fb", 32'(hz.fwd_b_sel), 32'd0); nxt();

    // Flush coincident with a load-use hazard
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1); nxt();
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    hz.flush = 1'b1;
    mid(); check_eq("flush_stall", 32'(hz.stall), 32'd0); nxt();
    hz.flush = 1'b0;
    nop();
    mid(); check_eq("flush_bubble_fa", 32'(hz.fwd_a_sel), 32'd0); nxt();
    mid(); check_eq("flush_bubble2_fa", 32'(hz.fwd_a_sel), 32'd0);
`ifdef HAZARD_STATS_EN
    check_eq("stat_stall", hz.stat_stall_cnt, 32'd1);
    check_eq("stat_fwd_mem", hz.stat_fwd_mem_cnt, 32'd3);
    check_eq("stat_fwd_wb", hz.stat_fwd_wb_cnt, 32'd2);
`endif
    nxt();

    // Reset mid-operation discards the in-flight load
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1); nxt();
    reset = 1'b1;
    nop(); nxt();
    reset = 1'b0;
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    mid();
    check_eq("mrst_stall", 32'(hz.stall), 32'd0);
`ifdef HAZARD_STATS_EN
    check_eq("mrst_stat_fwd_mem", hz.stat_fwd_mem_cnt, 32'd0);
`endif
    nxt();
    nop();
    mid(); check_eq("mrst_fa", 32'(hz.fwd_a_sel), 32'd0); nxt();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Control-side counterpart to the 3:1 ALU-operand forwarding mux in the 5-stage RISC-V pipeline. The mux consumes a 2-bit select; this block produces it.
- Keeps a shadow scoreboard of destination registers for the EX, MEM and WB stages, advanced each clock as instructions issue from ID.
- Drives per-operand select codes for the instruction currently in EX.
- Detects load-use hazards and requests a one-cycle stall with bubble insertion.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- XZERO_NOFWD, 1, when 1, register x0 never matches and is never forwarded.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs1  input  REG_ADDR_W  ID source register 1.
- id_rs2  input  REG_ADDR_W  ID source register 2.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- id_rd  input  REG_ADDR_W  ID destination register.
- id_reg_write  input  1  ID instruction writes rd.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  branch/jump redirect; kill the ID→EX issue.
- stall  output  1  hold PC and IF/ID; insert bubble into EX.
- fwd_a_sel  output  2  select for operand A mux: 00 = register file, 01 = MEM/WB, 10 = EX/MEM.
- fwd_b_sel  output  2  select for operand B mux, same encoding.

Behaviour:
- Internal state per stage:
  - EX: valid, rs1, rs2, use_rs1, use_rs2, rd, reg_write, mem_read.
  - MEM: valid, rd, reg_write, mem_read.
  - WB: valid, rd, reg_write.
- Reset:
  - All stage valids clear to 0. stall, fwd_a_sel and fwd_b_sel read 0 in the cycle after reset.
  - Reset asserted mid-operation discards all in-flight tracking the next edge, regardless of flush or stall.
- Each clock edge, absent reset:
  - MEM→WB: WB takes MEM's fields.
  - EX→MEM: MEM takes EX's fields.
  - ID→EX: EX captures the ID fields with valid = id_valid & ~stall & ~flush.
  - If stall or flush is high, EX.valid = 0 (bubble).
- The stall cycle does not block MEM/WB advance.
- stall is combinational from current state and ID inputs. It is 1 iff all of the following hold:
  - id_valid & ~flush;
  - EX.valid & EX.mem_read & EX.reg_write;
  - EX.rd != 0 (when XZERO_NOFWD = 1);
  - (id_use_rs1 & id_rs1 == EX.rd) | (id_use_rs2 & id_rs2 == EX.rd).
- Stall duration:
  - Exactly 1 cycle per load-use pair: next cycle EX is a bubble, so the condition clears.
  - The load is then in MEM and reaches WB when the consumer enters EX.
- fwd_a_sel (fwd_b_sel identical using EX.rs2 and EX.use_rs2):
  - 10 if MEM.valid & MEM.reg_write & MEM.rd != 0 & MEM.rd == EX.rs1 & EX.use_rs1.
  - Else 01 if the same test is true against WB.
  - Else 00.
  - Both selects are combinational from registered state and valid in the same cycle the instruction occupies EX.
- Priority:
  - EX/MEM over MEM/WB, so the youngest producer wins when MEM.rd == WB.rd.
  - Code 11 is never generated.
- Invariant: MEM.valid & MEM.mem_read matching an EX source must never occur. Verification asserts this.
- If EX.valid = 0, both selects are 00.
- flush and stall in the same cycle: flush wins, stall = 0, EX gets a bubble.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds outputs stat_stall_cnt [31:0], stat_fwd_mem_cnt [31:0] and stat_fwd_wb_cnt [31:0].
  - stat_stall_cnt increments each cycle stall = 1.
  - stat_fwd_mem_cnt increments once per cycle per operand whose select is 10.
  - stat_fwd_wb_cnt increments once per cycle per operand whose select is 01.
  - Counters clear on reset and wrap at 2^32 - 1 → 0.
- When undefined: no ports, no counters, no logic.

Test Plan:
- Reset: hold reset 2 cycles with id_valid = 1 → stall = 0, fwd_a_sel = fwd_b_sel = 00; first issue after release is tracked normally.
- ALU→ALU back-to-back:
  - Stimulus: issue add x5 (rd = 5, reg_write), then sub using rs1 = 5, rs2 = 5.
  - Response: when sub is in EX, fwd_a_sel = fwd_b_sel = 10; no stall.
- Distance-2 and priority:
  - Stimulus (a): issue add x7, a nop, then a consumer using rs2 = 7. Stimulus (b): issue two writers of x7 back-to-back, then the consumer.
  - Response: (a) fwd_b_sel = 01 and fwd_a_sel = 00. (b) fwd_b_sel = 10.
- Load-use:
  - Stimulus: issue lw x3 (mem_read), then add with rs1 = 3.
  - Response: stall = 1 for exactly one cycle and EX becomes a bubble; the add then enters EX with fwd_a_sel = 01.
- x0 and unused operands:
  - Stimulus (a): writer of x0, then reader of x0. Stimulus (b): writer of x4, then reader with rs2 = 4 and id_use_rs2 = 0.
  - Response: selects 00 and stall 0 in both cases.
- Flush vs stall:
  - Stimulus: assert flush in the same cycle as a load-use hazard.
  - Response: stall = 0; the next EX is a bubble. With HAZARD_STATS_EN, stat_stall_cnt is unchanged.
